transmissao_serial_16b: RTL and testbench
=========================================

# transmissao_serial_16b

- Transmits one 16-bit word as two UART frames on `tx_serial`: low byte first, then high byte.
- Frame format per byte: start bit, 8 data bits LSB first, odd parity, one stop bit.
- Produces exactly the framing the TUSCA measurement and configuration receivers decode.
- Used to send sensor words (temperature, humidity) and configuration words from the sensor-side board.

## Interface
Parameters:
- `CLOCK_FREQ`, 50_000_000 — clock frequency in Hz.
- `BAUD`, 9600 — line rate. Use 9600 for the measurement channel and 115200 for the configuration channel.
- Derived constant `CLKS_PER_BIT = CLOCK_FREQ / BAUD`, integer division (5208 at 9600, 434 at 115200). It must be at least 2.

Ports:
- `clock` in 1 — system clock.
- `reset` in 1 — asynchronous, active-low reset (0 = reset).
- `start` in 1 — request to send `data_in`. Sampled only in IDLE.
- `data_in` in 16 — word to send. Bits [7:0] go first, bits [15:8] second.
- `tx_serial` out 1 — serial line. Idles high.
- `busy` out 1 — high from the accepted `start` until `done`.
- `done` out 1 — one-cycle pulse when the word is complete.
- `db_estado` out 4 — current FSM state code, for debug.

## Operation
- FSM states: IDLE, START_BIT, DATA, PARITY, STOP, DONE.
- IDLE:
  - `tx_serial`=1, `busy`=0.
  - On `start`=1 at a clock edge: latch `data_in` into a 16-bit shift register, clear byte index and bit counter, go to START_BIT.
- START_BIT: `tx_serial`=0.
- DATA:
  - Drives bit[0] of the current byte, shifting right after each bit.
  - 8 bits total, counted by a 3-bit index.
- PARITY: `tx_serial` = ~^(current byte), so the 9 bits (data + parity) contain an odd number of ones. Compute it from the latched byte, not the shifted copy.
- STOP: `tx_serial`=1.
  - Byte index 0: go to START_BIT for the high byte.
  - Byte index 1: go to DONE.
- DONE: `done`=1 for one cycle, `busy` stays 1 during DONE, then go to IDLE.
- Each of START_BIT, each DATA bit, PARITY and STOP lasts exactly `CLKS_PER_BIT` cycles, timed by a bit-time counter that reloads on every bit boundary.
- `start` while busy is ignored. Changes to `data_in` after latching are ignored.
- Asynchronous reset, effective at any point including mid-frame:
  - `tx_serial`=1, `busy`=0, `done`=0, FSM in IDLE, counters 0.
  - The truncated frame is not resumed.
- `start` held high continuously: a new word starts on the first IDLE cycle after DONE. This gives one idle cycle between words beyond the stop bit.

## Timing
- All outputs are registered.
- Edge E accepts `start`. From E+1: `tx_serial`=0 and `busy`=1.
- Bit k (0 = start bit, 10 = stop bit) of byte b (0 or 1) occupies cycles E+1+(11·b+k)·CLKS_PER_BIT through E+(11·b+k+1)·CLKS_PER_BIT.
- `done`=1 in cycle E+1+22·CLKS_PER_BIT.
- `busy`=0 from cycle E+2+22·CLKS_PER_BIT.
- Back-to-back bytes: the high byte's start bit immediately follows the low byte's stop bit, with no extra idle.

## Structure
- Shared package `serial_pkg`:
  - FSM state encodings (shared with the receivers' debug decoding).
  - `PARITY_ODD` constant.
  - Function `clks_per_bit(clock_freq, baud)`.
- Sub-module `tx_serial_byte_paridade`:
  - Sends one 11-bit frame.
  - Ports: `clock`, `reset`, `start`, `dado[7:0]`, `tx_serial`, `pronto`.
  - The top level sequences two invocations (low byte, then high byte) and generates `busy`/`done`.

## Test plan
Unless stated otherwise, `BAUD` = 5_000_000, giving `CLKS_PER_BIT`=10.

1. Reset held low with `start`=1 → `tx_serial`=1, `busy`=0, `done`=0. Nothing is transmitted until `reset` rises and `start` is sampled.
2. Send 16'h2202 → line samples at bit centres:
   - Byte 0x02: 0, 0,1,0,0,0,0,0,0, 0, 1.
   - Byte 0x22: 0, 0,1,0,0,0,1,0,0, 1, 1.
   - `done` in cycle E+221.
3. Send 16'h1234 → bytes 0x34 then 0x12; parity bits 0 then 1.
4. Pulse `start` again at E+50 with a different `data_in` → ignored: the waveform equals scenario 2 and only one `done` occurs.
5. Assert `reset` low at E+75 (mid low byte) → `tx_serial`=1 in the same cycle. After release, a fresh 16'h1000 transmits correctly.
6. Loopback at `BAUD`=9600 into the TUSCA measurement receiver:
   - Send 16'h2202 then 16'h1234 → the receiver reports temperature 0x2202 and humidity 0x1234 with no parity error.
   - Repeat at 115200 into the configuration receiver with 16'h1000 → accepted.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and the matching receivers.
// Holds the FSM state codes seen on the db_estado debug ports, the parity sense,
// and the bit-time helper function.
package serial_pkg;

    // These codes also drive the receivers' debug decoders, so keep the values stable.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_BIT = 4'd1,
        ST_DATA      = 4'd2,
        ST_PARITY    = 4'd3,
        ST_STOP      = 4'd4,
        ST_DONE      = 4'd5
    } estado_t;

    // XOR of the eight data bits with this constant gives odd parity.
    localparam logic PARITY_ODD = 1'b1;

    // Clock cycles per serial bit (integer division). The result must be at least 2.
    function automatic int clks_per_bit(input int clock_freq, input int baud);
        return clock_freq / baud;
    endfunction

endpackage

// File: rtl/tx_serial_byte_paridade.sv
// tx_serial_byte_paridade: sends one 11-bit UART frame (start, 8 data bits LSB first, odd parity, stop).
// Latency: tx_serial goes low on the cycle after start is sampled; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: start is sampled only in IDLE and on the last cycle of STOP. A start seen at STOP chains the next frame with no gap.
// Ports: clock, reset (async, active low), start, dado[7:0] | tx_serial, pronto, db_estado[3:0]
module tx_serial_byte_paridade
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dado,
    output logic       tx_serial,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PENULT = CW'(CLKS_PER_BIT - 2);

    estado_t       r_estado;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;    // Unshifted copy of the byte, used to compute parity.
    logic          r_tx;
    logic          r_pronto;
    logic          w_fim_bit;

    assign w_fim_bit = (r_cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_byte   <= '0;
            r_tx     <= 1'b1;
            r_pronto <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                ST_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (start) begin
                        r_shift  <= dado;
                        r_byte   <= dado;
                        r_tx     <= 1'b0;
                        r_estado <= ST_START_BIT;
                    end
                end
                ST_START_BIT: begin
                    if (w_fim_bit) begin
                        r_cnt    <= '0;
                        r_tx     <= r_shift[0];
                        r_estado <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_fim_bit) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_idx    <= '0;
                            r_tx     <= (^r_byte) ^ PARITY_ODD;
                            r_estado <= ST_PARITY;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];    // Next bit, so the line and the shift stay aligned.
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_fim_bit) begin
                        r_cnt    <= '0;
                        r_tx     <= 1'b1;
                        r_estado <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_fim_bit) begin
                        r_cnt <= '0;
                        if (start) begin
                            r_shift  <= dado;
                            r_byte   <= dado;
                            r_tx     <= 1'b0;
                            r_estado <= ST_START_BIT;
                        end else begin
                            r_tx     <= 1'b1;
                            r_estado <= ST_IDLE;
                        end
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        // High on the final STOP cycle, so the parent can act on the same edge that ends the frame.
                        r_pronto <= (r_cnt == PENULT);
                    end
                end
                default: r_estado <= ST_IDLE;
            endcase
        end
    end

    assign tx_serial = r_tx;
    assign pronto    = r_pronto;
    assign db_estado = r_estado;

endmodule

// File: rtl/transmissao_serial_16b.sv
// transmissao_serial_16b: sends a 16-bit word as two odd-parity UART frames, low byte first.
// Latency: the start bit begins on the cycle after start is accepted; done pulses 22*CLKS_PER_BIT cycles after that.
// Backpressure: start is ignored while busy, and data_in is latched at acceptance.
// Ports: clock, reset (async, active low), start, data_in[15:0] | tx_serial, busy, done, db_estado[3:0]
module transmissao_serial_16b
    import serial_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 9600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic        tx_serial,
    output logic        busy,
    output logic        done,
    output logic [3:0]  db_estado
);

    // Must be at least 2 for the bit-time counter.
    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD);

    logic [15:0] r_word;
    logic        r_busy;
    logic        r_done;
    logic        r_byte_idx;
    logic        w_start_byte;
    logic [7:0]  w_dado;
    logic        w_pronto;
    logic [3:0]  w_estado_byte;

    // The byte sender chains into the high byte at the end of the low byte's STOP bit.
    // In IDLE, data_in goes straight through because the word is latched on the same edge.
    assign w_start_byte = (!r_busy && start) || (r_busy && !r_done && !r_byte_idx);
    assign w_dado       = r_busy ? r_word[15:8] : data_in[7:0];

    tx_serial_byte_paridade #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clock     (clock),
        .reset     (reset),
        .start     (w_start_byte),
        .dado      (w_dado),
        .tx_serial (tx_serial),
        .pronto    (w_pronto),
        .db_estado (w_estado_byte)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_word     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_byte_idx <= 1'b0;
        end else if (!r_busy) begin
            if (start) begin
                r_word     <= data_in;
                r_busy     <= 1'b1;
                r_byte_idx <= 1'b0;
            end
        end else if (r_done) begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else if (w_pronto) begin
            if (!r_byte_idx) begin
                r_byte_idx <= 1'b1;
            end else begin
                r_done <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    // The byte sender is idle during DONE, so report DONE from the top-level flag.
    assign db_estado = r_done ? ST_DONE : w_estado_byte;

endmodule

// File: tb/tb_transmissao_serial_16b.sv
module tb_transmissao_serial_16b;

    localparam int C = 10;          // CLKS_PER_BIT at 50 MHz / 5 Mbaud
    localparam int FRAME = 22 * C;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] data_in;
    logic        tx_serial;
    logic        busy;
    logic        done;
    logic [3:0]  db_estado;

    int n_vec = 0;
    int n_err = 0;

    transmissao_serial_16b #(
        .CLOCK_FREQ (50_000_000),
        .BAUD       (5_000_000)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .tx_serial (tx_serial),
        .busy      (busy),
        .done      (done),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for bit k of a frame that carries byte b and parity bit p.
    function automatic logic frame_bit(input logic [7:0] b, input logic p, input int k);
        logic r;
        if (k == 0)       r = 1'b0;
        else if (k <= 8)  r = b[k-1];
        else if (k == 9)  r = p;
        else              r = 1'b1;
        return r;
    endfunction

    // Sends one word and checks the line at every bit centre.
    // p0/p1 are the hand-computed parity bits. glitch_at pulses start mid-word,
    // reset_at asserts reset mid-word, and keep_start holds start high into the next word.
    task automatic send_word(input logic [15:0] w, input logic p0, input logic p1,
                             input bit keep_start, input int glitch_at, input int reset_at);
        int   n_done;
        int   last_t;
        int   bi, b, k;
        logic [7:0] by;
        logic exp_tx;
        n_done = 0;
        last_t = keep_start ? FRAME + 3 : FRAME + 6;
        @(negedge clock);
        start   = 1'b1;
        data_in = w;
        @(posedge clock);                           // edge E
        for (int t = 1; t <= last_t; t++) begin
            @(negedge clock);                       // inside cycle E+t
            if (reset_at != 0 && t == reset_at) begin
                reset = 1'b0;
                #1;
                chk("rst_mid_tx", tx_serial, 1);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_done", done, 0);
                chk("rst_mid_state", db_estado, 0);
                break;
            end
            if (done) n_done++;
            if (t <= FRAME && ((t - 1) % C) == C / 2) begin
                bi = (t - 1) / C;
                b  = bi / 11;
                k  = bi % 11;
                by = b ? w[15:8] : w[7:0];
                exp_tx = frame_bit(by, b ? p1 : p0, k);
                chk($sformatf("tx_%04h_b%0d_k%0d", w, b, k), tx_serial, exp_tx);
            end
            if (t == 1) begin
                chk("busy_first", busy, 1);
                chk("tx_first", tx_serial, 0);
                chk("state_first", db_estado, 1);
            end
            if (t == FRAME)     chk("done_early", done, 0);
            if (t == FRAME + 1) begin
                chk("done_pulse", done, 1);
                chk("busy_in_done", busy, 1);
                chk("state_done", db_estado, 5);
            end
            if (t == FRAME + 2) begin
                chk("busy_after", busy, 0);
                chk("tx_idle_gap", tx_serial, 1);
            end
            if (keep_start && t == FRAME + 3) begin
                chk("b2b_start_bit", tx_serial, 0);
                chk("b2b_busy", busy, 1);
            end
            // Drive after sampling.
            if (t == 1 && !keep_start) start = 1'b0;
            if (glitch_at != 0 && t == glitch_at) begin
                start   = 1'b1;
                data_in = ~w;
            end
            if (glitch_at != 0 && t == glitch_at + 1) start = 1'b0;
        end
        if (reset_at == 0 && !keep_start) chk("done_count", n_done, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 600; i++) begin
            if (!busy) break;
            @(negedge clock);
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b1;
        data_in = 16'hABCD;
        // 1: reset held low with start high
        repeat (5) @(negedge clock);
        chk("rst_tx", tx_serial, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", db_estado, 0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_rst_tx", tx_serial, 1);
        chk("post_rst_busy", busy, 0);

        // 2: 0x2202 -> bytes 0x02 (parity 0), 0x22 (parity 1)
        send_word(16'h2202, 1'b0, 1'b1, 1'b0, 0, 0);
        wait_idle("idle_2202");

        // 3: 0x1234 -> bytes 0x34 (parity 0), 0x12 (parity 1)
        send_word(16'h1234, 1'b0, 1'b1, 1'b0, 0, 0);
        wait_idle("idle_1234");

        // 4: start pulse with other data at E+50 is ignored
        send_word(16'h2202, 1'b0, 1'b1, 1'b0, 50, 0);
        wait_idle("idle_glitch");

        // 5: reset at E+75, then a fresh 0x1000 (bytes 0x00 parity 1, 0x10 parity 0)
        send_word(16'h1234, 1'b0, 1'b1, 1'b0, 0, 75);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_hold_tx", tx_serial, 1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_release_tx", tx_serial, 1);
        chk("rst_release_busy", busy, 0);
        send_word(16'h1000, 1'b1, 1'b0, 1'b0, 0, 0);
        wait_idle("idle_1000");

        // start held high: next word begins after one idle cycle (0x00FF: parity 1, 1)
        send_word(16'h00FF, 1'b1, 1'b1, 1'b1, 0, 0);
        start = 1'b0;
        wait_idle("idle_b2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
